fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC and issues one-outstanding reads to instruction memory.
//  Presents fetched words to the decoder over a valid/ready handshake.
//  Consumes PCSrc (taken branch / PC write, already gated by condition evaluation) and the branch target from execute.
//  On redirect, flushes stale fetched data and refetches from the target.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  INSTR_W       32             instruction/data width
// PORTS
//  CLK           in   1   clock; all state updates on posedge
//  RESET         in   1   asynchronous, active-high reset
//  PCSrc         in   1   redirect: load PC from BranchTarget (condition-qualified upstream)
//  BranchTarget  in   32  redirect target; word aligned, bits[1:0] ignored (forced 0)
//  IMemReq       out  1   read request; held high until IMemAck
//  IMemAddr      out  32  read address; stable while IMemReq high
//  IMemAck       in   1   read data valid this cycle; only meaningful while IMemReq=1
//  IMemRData     in   32  read data, sampled when IMemReq & IMemAck
//  InstrValid    out  1   Instr/InstrPC/PCPlus8 valid for decode
//  DecodeReady   in   1   decoder accepts; transfer when InstrValid & DecodeReady
//  Instr         out  32  fetched instruction
//  InstrPC       out  32  address of Instr
//  PCPlus8       out  32  InstrPC + 8 (architectural R15 read value)
// BEHAVIOUR
//  Reset (async): PC=RESET_VECTOR, state=IDLE, IMemReq=0, IMemAddr=0, InstrValid=0, Instr=0, InstrPC=0, PCPlus8=8.
//  Registers: PC (next fetch address), ReqAddr (drives IMemAddr), 1-entry output reg, FSM state.
//  OutFree = ~InstrValid | DecodeReady (output reg empty or draining this cycle).
//  FSM states:
//   IDLE: if OutFree & ~PCSrc -> ReqAddr<=PC, PC<=PC+4, go WAIT. If PCSrc: PC<=target, stay IDLE.
//   WAIT: IMemReq=1. Ack & ~PCSrc -> output reg <= {RData, ReqAddr}, InstrValid<=1; then if OutFree-after
//         (always true: reg was empty at issue) issue next only from IDLE -> go IDLE.
//         Ack & PCSrc -> drop data, PC<=target, go IDLE. ~Ack & PCSrc -> PC<=target, go DISCARD.
//   DISCARD: IMemReq=1, ReqAddr unchanged (protocol); on Ack drop data, go IDLE. Further PCSrc
//         overwrites PC with latest target.
//  IMemReq = (state==WAIT)|(state==DISCARD); combinational same-cycle ack is legal.
//  Issue rule guarantees output reg is empty when any ack lands; no data is ever lost except on flush.
//  PCSrc (any state): InstrValid<=0 next cycle (flush); a same-cycle DecodeReady transfer still counts.
//  Priority: RESET > PCSrc > Ack > issue. PCSrc beats a same-cycle ack (stale data dropped).
//  Output reg holds unchanged while InstrValid & ~DecodeReady (no bubble, no overwrite).
//  Latency: IDLE->WAIT 1 cycle; with 0-wait memory steady throughput 1 instr / 2 cycles.
//  Redirect-to-valid: 3 cycles with 0-wait memory (PCSrc edge, issue, ack).
//  PC arithmetic mod 2^32; wrap 32'hFFFF_FFFC -> 0 is legal, no flag.
//  RESET mid-request: request abandoned, IMemReq low immediately; memory must tolerate.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/WAIT/DISCARD, 2 bits), RESET_VECTOR default, word size const 4.
//  Single module; no sub-module required (output reg is 3 fields, inline).
// TESTING
//  1 Reset, 0-wait mem returning addr as data, DecodeReady=1 -> Instr 0,4,8,... InstrPC matches, PCPlus8=InstrPC+8.
//  2 Mem ack delayed 3 cycles -> IMemAddr/IMemReq stable all wait cycles; one InstrValid pulse per ack.
//  3 DecodeReady=0 for 5 cycles after first valid -> Instr held, IMemReq stays 0, no lost/duplicate words.
//  4 PCSrc=1, target 32'h100 during WAIT (ack 2 cycles later) -> DISCARD, stale data dropped, next Instr PC=0x100.
//  5 PCSrc and IMemAck same cycle, target 0x200 -> ack data never valid; next fetched InstrPC=0x200.
//  6 Assert RESET while IMemReq=1 -> IMemReq, InstrValid drop immediately; refetch from RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module : fetch_unit_pkg
//  Brief  : Shared constants for the instruction-fetch stage (FSM encoding,
//           reset vector default, word arithmetic helpers).
//  Rev    : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

  // Fetch FSM encoding (2 bits)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES           = 32'd4;
  // Architectural R15 reads two instructions ahead of the executing one
  localparam logic [31:0] R15_OFFSET           = 32'd8;

  // Redirect targets are word aligned; low address bits are forced to zero
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : fetch_unit
//  Brief  : Instruction-fetch stage. Owns the PC, issues one-outstanding reads
//           to instruction memory and hands fetched words to decode over a
//           valid/ready handshake. Redirects flush stale data and refetch.
//  Rev    : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          INSTR_W      = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PCSrc,
  input  logic [31:0]        BranchTarget,
  output logic               IMemReq,
  output logic [31:0]        IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemRData,
  output logic               InstrValid,
  input  logic               DecodeReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [31:0]        InstrPC,
  output logic [31:0]        PCPlus8
);

  logic [1:0]         state_q,    state_d;
  logic [31:0]        pc_q,       pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               valid_q,    valid_d;
  logic [INSTR_W-1:0] instr_q,    instr_d;
  logic [31:0]        ipc_q,      ipc_d;

  logic [31:0]        target_w;
  logic               out_free_w;

  assign target_w   = word_align(BranchTarget);
  // Output register is empty or is being drained by decode this cycle
  assign out_free_w = ~valid_q | DecodeReady;

  // Next-state logic: redirect beats ack, ack beats issue
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    valid_d    = valid_q & ~DecodeReady;

    case (state_q)
      ST_IDLE: begin
        if (PCSrc) begin
          pc_d = target_w;
        end else if (out_free_w) begin
          req_addr_d = pc_q;
          pc_d       = pc_q + WORD_BYTES;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PCSrc) begin
          pc_d    = target_w;
          state_d = IMemAck ? ST_IDLE : ST_DISCARD;
        end else if (IMemAck) begin
          // Issue only happens with a free output register, so nothing is overwritten here
          instr_d = IMemRData;
          ipc_d   = req_addr_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        // Request address is held until memory completes the abandoned read
        if (PCSrc) begin
          pc_d = target_w;
        end
        if (IMemAck) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect flushes whatever is in the output register
    if (PCSrc) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      req_addr_q <= 32'h0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      ipc_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
    end
  end

  assign IMemReq    = (state_q == ST_WAIT) | (state_q == ST_DISCARD);
  assign IMemAddr   = req_addr_q;
  assign InstrValid = valid_q;
  assign Instr      = instr_q;
  assign InstrPC    = ipc_q;
  assign PCPlus8    = ipc_q + R15_OFFSET;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module : tb_fetch_unit
//  Brief  : Self-checking bench for fetch_unit. A memory responder with a
//           programmable wait count and a program-order stream model
//           predict every delivered instruction and the request protocol.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;
  logic        InstrValid;
  logic        DecodeReady;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic [31:0] PCPlus8;

  fetch_unit #(.RESET_VECTOR(32'h0000_0000), .INSTR_W(32)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PCSrc        (PCSrc),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemRData    (IMemRData),
    .InstrValid   (InstrValid),
    .DecodeReady  (DecodeReady),
    .Instr        (Instr),
    .InstrPC      (InstrPC),
    .PCPlus8      (PCPlus8)
  );

  always #5 CLK = ~CLK;

  int          errors = 0;
  int          checks = 0;
  int          mem_delay;
  int          mem_cnt;
  int          n_xfer;
  int          lat;
  logic [31:0] mem_xor;
  logic [31:0] exp_pc;      // PC of next instruction decode should receive
  logic [31:0] fetch_pc;    // address of next fresh memory request
  bit          stale;       // outstanding request was overtaken by a redirect
  bit          prev_req;
  bit          prev_pending;
  logic [31:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    exp_pc       = 32'h0;
    fetch_pc     = 32'h0;
    stale        = 0;
    prev_req     = 0;
    prev_pending = 0;
    prev_addr    = 32'h0;
    mem_cnt      = 0;
  endtask

  // One clock: respond as memory, drive decode/redirect, predict, then check
  task automatic cycle(input bit pc, input logic [31:0] tgt, input bit rdy);
    bit          ack_good, exp_v, exp_req, hold;
    logic [31:0] h_i, h_pc, aligned;
    aligned = tgt & ~32'h3;

    if (prev_pending) begin
      chk("req_held", {31'b0, IMemReq}, 32'h1);
      chk("addr_stable", IMemAddr, prev_addr);
    end
    if (IMemReq && !prev_req) begin
      chk("fetch_addr", IMemAddr, fetch_pc);
      fetch_pc = fetch_pc + 32'd4;
      stale    = 0;
    end

    if (IMemReq && mem_cnt >= mem_delay) begin
      IMemAck   = 1'b1;
      IMemRData = IMemAddr ^ mem_xor;
      mem_cnt   = 0;
    end else begin
      IMemAck   = 1'b0;
      IMemRData = $urandom;
      mem_cnt   = IMemReq ? mem_cnt + 1 : 0;
    end
    PCSrc        = pc;
    BranchTarget = tgt;
    DecodeReady  = rdy;

    ack_good = IMemAck && !pc && !stale;
    if (IMemAck) stale = 0;
    else if (IMemReq && pc) stale = 1;
    exp_v   = !pc && (ack_good || (InstrValid && !rdy));
    exp_req = IMemReq ? !IMemAck : (!pc && (!InstrValid || rdy));

    if (InstrValid && rdy) begin
      chk("instr_pc", InstrPC, exp_pc);
      chk("instr", Instr, exp_pc ^ mem_xor);
      chk("pc_plus8", PCPlus8, exp_pc + 32'd8);
      exp_pc = exp_pc + 32'd4;
      n_xfer++;
    end
    if (pc) begin
      exp_pc   = aligned;
      fetch_pc = aligned;
    end
    hold = InstrValid && !rdy && !pc;
    h_i  = Instr;
    h_pc = InstrPC;
    prev_pending = IMemReq && !IMemAck;
    prev_addr    = IMemAddr;
    prev_req     = IMemReq;

    @(posedge CLK);
    #1;
    chk("valid", {31'b0, InstrValid}, {31'b0, exp_v});
    chk("req", {31'b0, IMemReq}, {31'b0, exp_req});
    if (hold) begin
      chk("hold_instr", Instr, h_i);
      chk("hold_pc", InstrPC, h_pc);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && !IMemReq; i++) cycle(0, 32'h0, 1);
    chk("wait_req", {31'b0, IMemReq}, 32'h1);
  endtask

  initial begin
    RESET = 1'b1; PCSrc = 1'b0; BranchTarget = 32'h0; IMemAck = 1'b0;
    IMemRData = 32'h0; DecodeReady = 1'b0;
    mem_delay = 0; mem_xor = 32'h0; n_xfer = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", {31'b0, InstrValid}, 32'h0);
    chk("rst_req", {31'b0, IMemReq}, 32'h0);
    chk("rst_addr", IMemAddr, 32'h0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_ipc", InstrPC, 32'h0);
    chk("rst_pc8", PCPlus8, 32'h8);
    RESET = 1'b0;

    // Zero-wait memory, data = address, decode always ready
    for (int i = 0; i < 20; i++) cycle(0, 32'h0, 1);
    chk("throughput", n_xfer, 32'd9);

    // Three wait cycles per read
    mem_delay = 3;
    for (int i = 0; i < 16; i++) cycle(0, 32'h0, 1);

    // Decode stall with a valid word held
    mem_delay = 0;
    for (int i = 0; i < 10 && !InstrValid; i++) cycle(0, 32'h0, 1);
    chk("stall_valid", {31'b0, InstrValid}, 32'h1);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 32'h0, 1);

    // Redirect while a read is outstanding -> discard
    mem_delay = 2;
    wait_req();
    cycle(1, 32'h0000_0100, 1);
    chk("discard_req", {31'b0, IMemReq}, 32'h1);
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 1);

    // Redirect coinciding with ack, and redirect-to-valid latency
    mem_delay = 0;
    wait_req();
    cycle(1, 32'h0000_0200, 1);
    lat = 1;
    while (!InstrValid && lat < 10) begin
      cycle(0, 32'h0, 1);
      lat++;
    end
    chk("redirect_lat", lat, 32'd3);
    chk("redirect_pc", InstrPC, 32'h0000_0200);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1);

    // Unaligned target and PC wrap through 0
    cycle(1, 32'hFFFF_FFFB, 1);
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 1);

    // Reset in the middle of a request
    mem_delay = 3;
    wait_req();
    RESET   = 1'b1;
    IMemAck = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, IMemReq}, 32'h0);
    chk("rst_mid_valid", {31'b0, InstrValid}, 32'h0);
    chk("rst_mid_addr", IMemAddr, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    mem_xor = $urandom;
    mem_delay = 0;
    for (int i = 0; i < 8; i++) cycle(0, 32'h0, 1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) mem_delay = $urandom_range(0, 3);
      cycle(($urandom_range(0, 15) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
